// File: rtl/bin2bcd_scan_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_scan_if
//   Bundles the conversion request and the display-facing outputs of
//   bin2bcd_scan.
//   master : drives value/load and observes results (the feeding logic)
//   slave  : the converter itself
//   Signals:
//     value    [13:0] binary value to convert (sampled on accepted load)
//     load            single-cycle conversion request
//     busy            conversion in progress
//     overflow        last accepted value exceeded 9999
//     digit1..digit4  units..thousands BCD digits
//     mux      [1:0]  free-running digit-select scan count
// ---------------------------------------------------------------------------
interface bin2bcd_scan_if;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    logic [3:0]  digit4;
    logic [1:0]  mux;

    modport master (
        output value, load,
        input  busy, overflow, digit1, digit2, digit3, digit4, mux
    );

    modport slave (
        input  value, load,
        output busy, overflow, digit1, digit2, digit3, digit4, mux
    );
endinterface

// File: rtl/bin2bcd_scan.sv
// ---------------------------------------------------------------------------
// bin2bcd_scan
//   Converts a 14-bit binary value into four BCD digits using a sequential
//   shift-add-3 (double-dabble) engine, one iteration per clock, and keeps a
//   free-running 2-bit digit-select counter for a downstream display mux.
//   Values above 9999 are clamped to 9999 and flagged via overflow.
//
//   Parameters:
//     SCAN_DIV  clk cycles each mux value is held (2..2^20)
//   Ports:
//     clk  system clock (rising edge)
//     rst  asynchronous, active-high reset
//     bus  bin2bcd_scan_if.slave: value/load in; busy, overflow,
//          digit1..digit4, mux out
//   Build option:
//     BIN2BCD_BLANK_LEADING_EN  when defined, leading zero digits (from
//     digit4 downward, never digit1) are committed as 4'hF (blank code).
// ---------------------------------------------------------------------------
module bin2bcd_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst,
    bin2bcd_scan_if.slave   bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t       state_reg, state_next;
    logic [13:0]  bin_reg;
    logic [15:0]  bcd_reg;
    logic [3:0]   iter_reg;
    logic         pend_ovf_reg;
    logic         busy_reg;
    logic         ovf_reg;
    logic [15:0]  digit_reg;
    logic [PW-1:0] presc_reg;
    logic [1:0]   mux_reg;

    logic [15:0]  bcd_adj;
    logic [15:0]  commit_digits;
    logic         value_over;

    assign value_over = (bus.value > 14'd9999);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.load) state_next = SHIFT;
            // iter_reg counts completed iterations; 13 means this is the 14th
            SHIFT:   if (iter_reg == 4'd13) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- add-3 correction per nibble ----------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // ---------------- digits written at COMMIT ----------------
`ifdef BIN2BCD_BLANK_LEADING_EN
    // blank_run[gi] is set while every digit from digit4 down to gi is zero
    logic [3:1] blank_run;
    assign blank_run[3] = (bcd_reg[15:12] == 4'd0);
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_blank_run
            assign blank_run[gi] = blank_run[gi+1] && (bcd_reg[gi*4 +: 4] == 4'd0);
        end
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign commit_digits[gi*4 +: 4] = blank_run[gi] ? 4'hF : bcd_reg[gi*4 +: 4];
        end
    endgenerate
    // units digit always shows, so a zero value reads as a single 0
    assign commit_digits[3:0] = bcd_reg[3:0];
`else
    assign commit_digits = bcd_reg;
`endif

    // ---------------- conversion datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg      <= '0;
            bcd_reg      <= '0;
            iter_reg     <= '0;
            pend_ovf_reg <= 1'b0;
            busy_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            digit_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.load) begin
                        bin_reg      <= value_over ? 14'd9999 : bus.value;
                        pend_ovf_reg <= value_over;
                        bcd_reg      <= '0;
                        iter_reg     <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                SHIFT: begin
                    bcd_reg  <= {bcd_adj[14:0], bin_reg[13]};
                    bin_reg  <= {bin_reg[12:0], 1'b0};
                    iter_reg <= iter_reg + 4'd1;
                end
                COMMIT: begin
                    // digits and overflow update together: no partial result
                    digit_reg <= commit_digits;
                    ovf_reg   <= pend_ovf_reg;
                    busy_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- scan counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            mux_reg   <= 2'd0;
        end else if (presc_reg == PW'(SCAN_DIV - 1)) begin
            presc_reg <= '0;
            mux_reg   <= mux_reg + 2'd1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.overflow = ovf_reg;
    assign bus.digit1   = digit_reg[3:0];
    assign bus.digit2   = digit_reg[7:4];
    assign bus.digit3   = digit_reg[11:8];
    assign bus.digit4   = digit_reg[15:12];
    assign bus.mux      = mux_reg;

endmodule

// File: tb/tb_bin2bcd_scan.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_scan
//   Self-checking bench for bin2bcd_scan with SCAN_DIV=4. A table of fixed
//   vectors, hand-written corner sequences and random values are compared
//   against an arithmetic reference model; the mux output is checked on every
//   cycle against the cycle count since reset.
// ---------------------------------------------------------------------------
module tb_bin2bcd_scan;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin2bcd_scan_if bus ();

    bin2bcd_scan #(.SCAN_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] last_dig = 16'h0000;
    logic        last_ovf = 1'b0;

    typedef struct {
        logic [13:0] value;
        logic [3:0]  d4, d3, d2, d1;
        logic        ovf;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] digits_now();
        return {bus.digit4, bus.digit3, bus.digit2, bus.digit1};
    endfunction

    // leading-zero blanking as seen on the display (identity when disabled)
    function automatic logic [15:0] blank_lead(input logic [15:0] d);
        logic [15:0] r;
        r = d;
`ifdef BIN2BCD_BLANK_LEADING_EN
        if (d[15:12] == 4'd0) begin
            r[15:12] = 4'hF;
            if (d[11:8] == 4'd0) begin
                r[11:8] = 4'hF;
                if (d[7:4] == 4'd0) r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    // reference: clamp, split into decimal digits, blank; bit 16 = overflow
    function automatic logic [16:0] model(input int unsigned v);
        int unsigned c;
        logic [15:0] d;
        c = (v > 9999) ? 9999 : v;
        d[15:12] = 4'((c / 1000) % 10);
        d[11:8]  = 4'((c / 100) % 10);
        d[7:4]   = 4'((c / 10) % 10);
        d[3:0]   = 4'(c % 10);
        return {(v > 9999), blank_lead(d)};
    endfunction

    // ---------------- scan counter monitor ----------------
    int edges = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    always @(negedge clk) begin
        check("mux", {30'd0, bus.mux}, (edges / DIV) % 4);
    end

    // Must be called at a negedge; returns at the negedge after commit.
    task automatic run_conv(input logic [13:0] v, input logic [15:0] exp_dig,
                            input logic exp_ovf, input bit inject, input string name);
        int cnt;
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 20) begin
            cnt++;
            if (inject && cnt == 5) begin
                bus.value = 14'd777;
                bus.load  = 1'b1;
            end else begin
                bus.load  = 1'b0;
            end
            check({name, " hold"}, {15'd0, bus.overflow, digits_now()}, {15'd0, last_ovf, last_dig});
            @(negedge clk);
        end
        bus.load = 1'b0;
        check({name, " busy_cycles"}, cnt, 15);
        check({name, " digits"}, {16'd0, digits_now()}, {16'd0, exp_dig});
        check({name, " overflow"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
        $display("[TB] load %0d -> digits %h overflow %0b (expected %h %0b)",
                 v, digits_now(), bus.overflow, exp_dig, exp_ovf);
        last_dig = exp_dig;
        last_ovf = exp_ovf;
    endtask

    initial begin
        logic [16:0] m;
        logic [13:0] rv;

        tbl[0] = '{14'd1234,  4'd1, 4'd2, 4'd3, 4'd4, 1'b0};
        tbl[1] = '{14'd16383, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1};
        tbl[2] = '{14'd0,     4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[3] = '{14'd9999,  4'd9, 4'd9, 4'd9, 4'd9, 1'b0};
        tbl[4] = '{14'd10000, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1};
        tbl[5] = '{14'd7,     4'd0, 4'd0, 4'd0, 4'd7, 1'b0};
        tbl[6] = '{14'd1005,  4'd1, 4'd0, 4'd0, 4'd5, 1'b0};
        tbl[7] = '{14'd100,   4'd0, 4'd1, 4'd0, 4'd0, 1'b0};
        tbl[8] = '{14'd8090,  4'd8, 4'd0, 4'd9, 4'd0, 1'b0};

        bus.value = '0;
        bus.load  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy",     {31'd0, bus.busy},     0);
        check("reset overflow", {31'd0, bus.overflow}, 0);
        check("reset digits",   {16'd0, digits_now()}, 0);
        check("reset mux",      {30'd0, bus.mux},      0);
        rst = 1'b0;

        // fixed vectors, back to back
        for (int i = 0; i < 9; i++) begin
            run_conv(tbl[i].value,
                     blank_lead({tbl[i].d4, tbl[i].d3, tbl[i].d2, tbl[i].d1}),
                     tbl[i].ovf, 1'b0, $sformatf("tbl%0d", i));
        end

        // load during busy is ignored; a load at E16 is taken
        m = model(42);
        run_conv(14'd42, m[15:0], m[16], 1'b1, "busy_ignore");
        m = model(777);
        run_conv(14'd777, m[15:0], m[16], 1'b0, "load_e16");

        // random values checked against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            rv = 14'($urandom_range(0, 16383));
            m  = model(rv);
            run_conv(rv, m[15:0], m[16], 1'b0, $sformatf("rand%0d", i));
        end

        // reset in the middle of a conversion
        bus.value = 14'd4321;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset busy",     {31'd0, bus.busy},     0);
        check("midreset overflow", {31'd0, bus.overflow}, 0);
        check("midreset digits",   {16'd0, digits_now()}, 0);
        check("midreset mux",      {30'd0, bus.mux},      0);
        $display("[TB] reset mid-conversion -> busy %0b digits %h", bus.busy, digits_now());
        last_dig = 16'h0000;
        last_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m = model(56);
        run_conv(14'd56, m[15:0], m[16], 1'b0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
